// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl
//  Description : Single-outstanding instruction fetch controller. Issues one
//                word-aligned request at a time, buffers the returned word for
//                decode, and handles branch/jump redirects by dropping any
//                in-flight or buffered instruction.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  // instruction memory request/response
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  // decode side
  output logic        o_instr_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_instr_pc,
  input  logic        i_instr_ready,
  // redirect from execute
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  // status
  output logic        o_misaligned,
  output logic [31:0] o_fetch_count
);

  // FSM encoding
  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_REQ  = 3'd1;
  localparam logic [2:0] c_WAIT = 3'd2;
  localparam logic [2:0] c_HOLD = 3'd3;
  localparam logic [2:0] c_DROP = 3'd4;

  logic [2:0]  state_q,      state_d;
  logic [31:0] pc_q,         pc_d;
  logic [31:0] instr_q,      instr_d;
  logic [31:0] instr_pc_q,   instr_pc_d;
  logic        misaligned_q, misaligned_d;
  logic [31:0] count_q,      count_d;

  // A redirect is only honoured once the FSM has left IDLE.
  logic w_redirect;
  assign w_redirect = i_redirect && (state_q != c_IDLE);

  // Next-state logic: redirect overrides every other event in the active states.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    instr_pc_d   = instr_pc_q;
    misaligned_d = misaligned_q;
    count_d      = count_q;

    if (w_redirect) begin
      // Low address bits are cleared so the request stays word-aligned;
      // the sticky flag records that the target was not.
      pc_d = {i_redirect_pc[31:2], 2'b00};
      if (i_redirect_pc[1:0] != 2'b00) begin
        misaligned_d = 1'b1;
      end
    end

    case (state_q)
      c_IDLE: begin
        state_d = c_REQ;
      end
      c_REQ: begin
        // A granted request that was redirected still owes a response,
        // which must be swallowed in DROP.
        if (i_imem_gnt) begin
          state_d = w_redirect ? c_DROP : c_WAIT;
        end
      end
      c_WAIT: begin
        if (w_redirect) begin
          state_d = i_imem_rvalid ? c_REQ : c_DROP;
        end else if (i_imem_rvalid) begin
          instr_d    = i_imem_rdata;
          instr_pc_d = pc_q;
          pc_d       = pc_q + 32'd4;
          state_d    = c_HOLD;
        end
      end
      c_HOLD: begin
        if (w_redirect) begin
          state_d = c_REQ;
        end else if (i_instr_ready) begin
          count_d = count_q + 32'd1;
          state_d = c_REQ;
        end
      end
      c_DROP: begin
        if (i_imem_rvalid) begin
          state_d = c_REQ;
        end
      end
      default: begin
        state_d = c_IDLE;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= c_IDLE;
      pc_q         <= RESET_PC;
      instr_q      <= 32'd0;
      instr_pc_q   <= 32'd0;
      misaligned_q <= 1'b0;
      count_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      instr_pc_q   <= instr_pc_d;
      misaligned_q <= misaligned_d;
      count_q      <= count_d;
    end
  end

  assign o_imem_req    = (state_q == c_REQ);
  assign o_imem_addr   = pc_q;
  assign o_instr_valid = (state_q == c_HOLD);
  assign o_instr       = instr_q;
  assign o_instr_pc    = instr_pc_q;
  assign o_misaligned  = misaligned_q;
  assign o_fetch_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_ctrl
//  Description : Self-checking bench for fetch_ctrl. A table of fetch
//                transactions is replayed through a small memory/decode
//                driver; delivered words are checked against a scoreboard.
//                Hand-written sequences cover redirect, wrap and reset cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        misaligned;
  logic [31:0] fetch_count;

  // 100 MHz-style clock
  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .o_imem_req    (imem_req),
    .o_imem_addr   (imem_addr),
    .i_imem_gnt    (imem_gnt),
    .i_imem_rvalid (imem_rvalid),
    .i_imem_rdata  (imem_rdata),
    .o_instr_valid (instr_valid),
    .o_instr       (instr),
    .o_instr_pc    (instr_pc),
    .i_instr_ready (instr_ready),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_misaligned  (misaligned),
    .o_fetch_count (fetch_count)
  );

  typedef struct {
    logic [31:0] rdata;
    int          gnt_wait;
    int          rv_wait;
    int          rdy_wait;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  vec_t        tbl [6];
  exp_t        sb [$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a request and check it targets the expected PC.
  task automatic wait_req(input string name);
    int k = 0;
    while (imem_req !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk({name, " req"}, 32'(imem_req), 32'd1);
    chk({name, " addr"}, imem_addr, exp_pc);
  endtask

  // Drive one fetch up to the HOLD state and record the expected word.
  task automatic issue(input vec_t v, input string name);
    wait_req(name);
    for (int i = 0; i < v.gnt_wait; i++) begin
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b1;            // stray response while nothing is outstanding
      imem_rdata  = $urandom;
      tick();
      imem_rvalid = 1'b0;
      chk({name, " req held"}, 32'(imem_req), 32'd1);
      chk({name, " addr held"}, imem_addr, exp_pc);
    end
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    chk({name, " req after gnt"}, 32'(imem_req), 32'd0);
    for (int i = 0; i < v.rv_wait; i++) begin
      tick();
      chk({name, " valid in wait"}, 32'(instr_valid), 32'd0);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = v.rdata;
    sb.push_back('{instr: v.rdata, pc: exp_pc});
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    chk({name, " valid"}, 32'(instr_valid), 32'd1);
    exp_pc = exp_pc + 32'd4;
  endtask

  // Stall decode for rdy_wait cycles, then accept and check against scoreboard.
  task automatic accept(input int rdy_wait, input string name);
    exp_t e;
    if (sb.size() == 0) begin
      chk({name, " scoreboard empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    for (int i = 0; i < rdy_wait; i++) begin
      instr_ready = 1'b0;
      imem_rvalid = 1'b1;            // stray response in HOLD must be ignored
      imem_rdata  = $urandom;
      tick();
      imem_rvalid = 1'b0;
      chk({name, " stall valid"}, 32'(instr_valid), 32'd1);
      chk({name, " stall instr"}, instr, e.instr);
      chk({name, " stall pc"}, instr_pc, e.pc);
      chk({name, " stall req"}, 32'(imem_req), 32'd0);
      chk({name, " stall count"}, fetch_count, exp_count);
    end
    chk({name, " instr"}, instr, e.instr);
    chk({name, " instr_pc"}, instr_pc, e.pc);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    exp_count = exp_count + 32'd1;
    chk({name, " count"}, fetch_count, exp_count);
    chk({name, " valid after accept"}, 32'(instr_valid), 32'd0);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    exp_t discard;

    tbl[0] = '{rdata: 32'h0050_0093, gnt_wait: 0, rv_wait: 0, rdy_wait: 0};
    tbl[1] = '{rdata: 32'h00a0_0113, gnt_wait: 0, rv_wait: 0, rdy_wait: 5};
    tbl[2] = '{rdata: 32'h0020_81b3, gnt_wait: 2, rv_wait: 0, rdy_wait: 0};
    tbl[3] = '{rdata: 32'hfe01_0113, gnt_wait: 0, rv_wait: 3, rdy_wait: 1};
    tbl[4] = '{rdata: 32'h0011_2e23, gnt_wait: 1, rv_wait: 1, rdy_wait: 2};
    tbl[5] = '{rdata: 32'h0000_8067, gnt_wait: 3, rv_wait: 2, rdy_wait: 0};

    rst         = 1'b1;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    exp_pc      = RESET_PC;
    exp_count   = 32'd0;

    repeat (2) tick();
    chk("reset req", 32'(imem_req), 32'd0);
    chk("reset valid", 32'(instr_valid), 32'd0);
    chk("reset addr", imem_addr, RESET_PC);
    chk("reset count", fetch_count, 32'd0);
    chk("reset misaligned", 32'(misaligned), 32'd0);
    rst = 1'b0;

    // Table-driven fetches; entry 0 is the minimum-latency first fetch.
    for (int i = 0; i < 6; i++) begin
      issue(tbl[i], $sformatf("vec%0d", i));
      accept(tbl[i].rdy_wait, $sformatf("vec%0d", i));
    end
    chk("seq after table count", fetch_count, 32'd6);

    // Redirect while WAIT, late response is dropped.
    wait_req("redir_wait");
    imem_gnt = 1'b1;
    tick();
    imem_gnt    = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    tick();
    redirect = 1'b0;
    chk("redir_wait drop req", 32'(imem_req), 32'd0);
    tick();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hdead_beef;
    tick();
    imem_rvalid = 1'b0;
    chk("redir_wait valid", 32'(instr_valid), 32'd0);
    chk("redir_wait count", fetch_count, exp_count);
    exp_pc = 32'h0000_0100;
    wait_req("redir_wait next");

    // Redirect in WAIT with response in the same cycle goes straight to REQ.
    imem_gnt = 1'b1;
    tick();
    imem_gnt    = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0180;
    imem_rvalid = 1'b1;
    tick();
    redirect    = 1'b0;
    imem_rvalid = 1'b0;
    chk("redir_wait_rv req", 32'(imem_req), 32'd1);
    chk("redir_wait_rv addr", imem_addr, 32'h0000_0180);
    chk("redir_wait_rv valid", 32'(instr_valid), 32'd0);
    exp_pc = 32'h0000_0180;

    // Redirect with grant in REQ goes to DROP; redirect again in DROP with response.
    imem_gnt    = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_01c0;
    tick();
    imem_gnt = 1'b0;
    redirect = 1'b0;
    chk("redir_req_gnt req", 32'(imem_req), 32'd0);
    chk("redir_req_gnt addr", imem_addr, 32'h0000_01c0);
    imem_rvalid = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_01e0;
    tick();
    imem_rvalid = 1'b0;
    redirect    = 1'b0;
    chk("redir_drop req", 32'(imem_req), 32'd1);
    chk("redir_drop addr", imem_addr, 32'h0000_01e0);
    chk("redir_drop valid", 32'(instr_valid), 32'd0);
    exp_pc = 32'h0000_01e0;

    // Misaligned redirect target is aligned and flagged stickily.
    chk("misaligned before", 32'(misaligned), 32'd0);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0202;
    tick();
    redirect = 1'b0;
    chk("misaligned set", 32'(misaligned), 32'd1);
    exp_pc = 32'h0000_0200;
    v = '{rdata: 32'h1234_5678, gnt_wait: 0, rv_wait: 1, rdy_wait: 0};
    issue(v, "misal");
    accept(0, "misal");
    chk("misaligned sticky", 32'(misaligned), 32'd1);

    // Redirect and ready together in HOLD: nothing is delivered.
    v = '{rdata: 32'hcafe_f00d, gnt_wait: 0, rv_wait: 0, rdy_wait: 0};
    issue(v, "redir_hold");
    discard = sb.pop_front();
    instr_ready = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0300;
    tick();
    instr_ready = 1'b0;
    redirect    = 1'b0;
    chk("redir_hold count", fetch_count, exp_count);
    chk("redir_hold valid", 32'(instr_valid), 32'd0);
    exp_pc = 32'h0000_0300;
    wait_req("redir_hold next");

    // PC wraps from the top of the address space to zero.
    redirect    = 1'b1;
    redirect_pc = 32'hffff_fffc;
    tick();
    redirect = 1'b0;
    exp_pc   = 32'hffff_fffc;
    v = '{rdata: 32'h0000_0013, gnt_wait: 0, rv_wait: 0, rdy_wait: 0};
    issue(v, "wrap");
    accept(0, "wrap");
    wait_req("wrap next");

    // Asynchronous reset in WAIT with PC=0x40.
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0043;
    tick();
    redirect = 1'b0;
    exp_pc   = 32'h0000_0040;
    wait_req("pre_reset");
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    chk("pre_reset wait req", 32'(imem_req), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("async reset req", 32'(imem_req), 32'd0);
    chk("async reset valid", 32'(instr_valid), 32'd0);
    chk("async reset instr", instr, 32'd0);
    chk("async reset instr_pc", instr_pc, 32'd0);
    chk("async reset misaligned", 32'(misaligned), 32'd0);
    chk("async reset count", fetch_count, 32'd0);
    chk("async reset addr", imem_addr, RESET_PC);

    // Release with a redirect pending: it lands in IDLE and must be ignored.
    tick();
    rst         = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0503;
    tick();
    redirect  = 1'b0;
    exp_pc    = RESET_PC;
    exp_count = 32'd0;
    sb.delete();
    chk("post_reset req", 32'(imem_req), 32'd1);
    chk("post_reset addr", imem_addr, RESET_PC);
    chk("post_reset misaligned", 32'(misaligned), 32'd0);
    v = '{rdata: 32'h0050_0093, gnt_wait: 0, rv_wait: 0, rdy_wait: 0};
    issue(v, "post_reset");
    accept(0, "post_reset");
    wait_req("post_reset next");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, address of first fetch after reset.
REQ-002 Port: i_clk  in  1  sole clock; all state updates on rising edge.
REQ-003 Port: i_reset  in  1  asynchronous, active-high reset.
REQ-004 Port: o_imem_req  out  1  instruction-memory request valid.
REQ-005 Port: o_imem_addr  out  32  request address, word-aligned.
REQ-006 Port: i_imem_gnt  in  1  request accepted when high in the same cycle as o_imem_req.
REQ-007 Port: i_imem_rvalid  in  1  response data valid.
REQ-008 Port: i_imem_rdata  in  32  response instruction word.
REQ-009 Port: o_instr_valid  out  1  buffered instruction available to decode/immediate generation.
REQ-010 Port: o_instr  out  32  buffered instruction word.
REQ-011 Port: o_instr_pc  out  32  address of o_instr.
REQ-012 Port: i_instr_ready  in  1  decode accepts o_instr when high with o_instr_valid.
REQ-013 Port: i_redirect  in  1  branch/jump redirect from execute.
REQ-014 Port: i_redirect_pc  in  32  redirect target.
REQ-015 Port: o_misaligned  out  1  sticky flag: a redirect target had bits [1:0] nonzero.
REQ-016 Port: o_fetch_count  out  32  count of instructions delivered (valid and ready).

Function
REQ-017 FSM states SHALL be IDLE, REQ, WAIT, HOLD, DROP, with at most one outstanding memory request at any time.
REQ-018 o_imem_req SHALL be 1 only in REQ; o_instr_valid SHALL be 1 only in HOLD; o_imem_addr SHALL equal the internal PC register.
REQ-019 IDLE SHALL go to REQ unconditionally on the next edge.
REQ-020 REQ, no redirect: gnt=1 -> WAIT; gnt=0 -> stay REQ, address held stable.
REQ-021 WAIT, no redirect: rvalid=1 -> capture rdata into o_instr, PC into o_instr_pc, PC <= PC+4 (mod 2^32, wrap from 32'hFFFF_FFFC to 0), go HOLD; rvalid=0 -> stay WAIT.
REQ-022 HOLD, no redirect: ready=1 -> o_fetch_count +1 (wraps at 2^32), go REQ; ready=0 -> hold o_instr/o_instr_pc stable.
REQ-023 DROP, no redirect: rvalid=1 -> discard data, go REQ; rvalid=0 -> stay DROP.
REQ-024 i_redirect SHALL take priority over every other event in every state except IDLE, loading PC <= {i_redirect_pc[31:2],2'b00}.
REQ-025 Redirect in REQ: gnt=1 same cycle -> DROP; gnt=0 -> stay REQ.
REQ-026 Redirect in WAIT: rvalid=1 same cycle -> discard data, go REQ; rvalid=0 -> DROP.
REQ-027 Redirect in HOLD: discard buffered instruction, o_fetch_count SHALL NOT increment even if ready=1, go REQ.
REQ-028 Redirect in DROP: rvalid=1 same cycle -> go REQ; rvalid=0 -> stay DROP.
REQ-029 Redirect in IDLE SHALL be ignored.
REQ-030 Redirect with i_redirect_pc[1:0]!=0 SHALL set o_misaligned on the next edge; it SHALL stay set until reset.
REQ-031 rvalid in REQ, HOLD or IDLE (no outstanding request) SHALL be ignored.
REQ-032 Minimum latency: request to o_instr_valid = 2 cycles with gnt and rvalid on first opportunity.

Reset
REQ-033 While i_reset=1 (asynchronously, any time including mid-transaction): state=IDLE, PC=RESET_PC, o_imem_req=0, o_instr_valid=0, o_instr=0, o_instr_pc=0, o_misaligned=0, o_fetch_count=0.
REQ-034 After reset the memory side SHALL see no request until the first edge after deassertion moves the FSM to REQ; any in-flight response is the memory's responsibility to cancel.

Verification
REQ-035 Reset release, gnt=1, rvalid next cycle with 32'h00500093, ready=1 -> o_imem_addr=0, o_instr=32'h00500093, o_instr_pc=0, o_fetch_count=1, next o_imem_addr=4.
REQ-036 HOLD with ready=0 for 5 cycles -> o_instr_valid=1, o_instr/o_instr_pc stable, o_imem_req=0, count unchanged.
REQ-037 Redirect to 32'h100 while in WAIT, rvalid 2 cycles later -> data dropped, next request addr=32'h100, count unchanged.
REQ-038 Redirect to 32'h202 -> o_misaligned=1, next request addr=32'h200; stays 1 until i_reset.
REQ-039 Redirect and ready together in HOLD -> count unchanged, next request addr=redirect target.
REQ-040 Assert i_reset in WAIT with PC=32'h40 -> all outputs at reset values immediately; after release first request addr=RESET_PC.
